// File: rtl/fft_feeder_pkg.sv
`default_nettype none
// ============================================================================
// fft_feeder_pkg : shared sample type, FSM encodings and defaults for the feeder
// Rev 1.0
// ============================================================================
package fft_feeder_pkg;
    localparam logic [15:0] CFG_WORD_DEFAULT = 16'h00C7;
    localparam int          IQ_W             = 16;

    typedef struct packed {
        logic signed [IQ_W-1:0] im;
        logic signed [IQ_W-1:0] re;
    } iq_sample_t;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_FRAME = 2'd1,
        W_DROP  = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        C_SEND = 1'b0,
        C_DONE = 1'b1
    } cfg_state_t;
endpackage
`default_nettype wire

// File: rtl/fft_frame_feeder_if.sv
`default_nettype none
// ============================================================================
// fft_frame_feeder_if : fr_sync input, FFT config/data AXI-Stream and status
// Rev 1.0
// ============================================================================
interface fft_frame_feeder_if #(
    parameter int pDAT_W = 16
);
    logic                  fr_sync_ival;
    logic                  fr_sync_isop;
    logic                  fr_sync_ilast;
    logic [2*pDAT_W-1:0]   fr_sync_idata;
    logic [15:0]           m_axis_cfg_tdata;
    logic                  m_axis_cfg_tvalid;
    logic                  m_axis_cfg_tready;
    logic [2*pDAT_W-1:0]   m_axis_data_tdata;
    logic                  m_axis_data_tvalid;
    logic                  m_axis_data_tready;
    logic                  m_axis_data_tlast;
    logic                  ostat_overflow;
    logic                  ostat_frame_err;
    logic [15:0]           ostat_frames;

    modport master (
        input  fr_sync_ival, fr_sync_isop, fr_sync_ilast, fr_sync_idata,
        input  m_axis_cfg_tready, m_axis_data_tready,
        output m_axis_cfg_tdata, m_axis_cfg_tvalid,
        output m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
        output ostat_overflow, ostat_frame_err, ostat_frames
    );

    modport slave (
        output fr_sync_ival, fr_sync_isop, fr_sync_ilast, fr_sync_idata,
        output m_axis_cfg_tready, m_axis_data_tready,
        input  m_axis_cfg_tdata, m_axis_cfg_tvalid,
        input  m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
        input  ostat_overflow, ostat_frame_err, ostat_frames
    );
endinterface
`default_nettype wire

// File: rtl/feeder_sdp_ram.sv
`default_nettype none
// ============================================================================
// feeder_sdp_ram : simple dual-port RAM, one write / one registered read port
// Rev 1.0
// ============================================================================
module feeder_sdp_ram #(
    parameter int pDW = 32,
    parameter int pAW = 11
) (
    input  wire logic           iclk,
    input  wire logic           i_we,
    input  wire logic [pAW-1:0] i_waddr,
    input  wire logic [pDW-1:0] i_wdata,
    input  wire logic           i_re,
    input  wire logic [pAW-1:0] i_raddr,
    output logic      [pDW-1:0] o_rdata
);
    logic [pDW-1:0] r_mem [0:(1<<pAW)-1];
    logic [pDW-1:0] r_rdata;

    // Read register holds its value while i_re is low; the feeder uses it as a skid slot.
    always_ff @(posedge iclk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/fft_frame_feeder.sv
`default_nettype none
// ============================================================================
// fft_frame_feeder : whole-frame store-and-forward from fr_sync to FFT AXI-Stream
// Rev 1.0   (optional frame counter: FEEDER_STATS_EN)
// ============================================================================
module fft_frame_feeder
    import fft_feeder_pkg::*;
#(
    parameter int          pDAT_W      = 16,
    parameter int          pFRAME_LEN  = 1024,
    parameter int          pFIFO_DEPTH = 2048,
    parameter logic [15:0] pCFG_WORD   = CFG_WORD_DEFAULT
) (
    input wire logic      iclk,
    input wire logic      irst,
    fft_frame_feeder_if.master bus
);
    localparam int c_AW = $clog2(pFIFO_DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam int c_CW = $clog2(pFRAME_LEN + 1);
    localparam int c_SW = 2 * pDAT_W;
    localparam logic [c_PW-1:0] c_MAX_USED = c_PW'(pFIFO_DEPTH - pFRAME_LEN);
    localparam logic [c_CW-1:0] c_LAST_CNT = c_CW'(pFRAME_LEN - 1);

    cfg_state_t      r_cfg_state, w_cfg_nxt;
    logic            r_cfg_tvalid;
    wr_state_t       r_wr_state, w_wr_nxt;
    logic [c_PW-1:0] r_wr_ptr, w_wr_ptr_nxt, r_commit_ptr, w_commit_nxt, r_rd_ptr, w_used;
    logic [c_CW-1:0] r_wcnt, w_wcnt_nxt, r_rcnt;
    logic            w_we, w_err, w_ovf_set, r_ovf, r_frame_err;
    logic            r_pend, r_tvalid, r_tlast, w_avail, w_load, w_re;
    logic [c_SW-1:0] r_tdata, w_rdata;

    // ---------------- config word, sent once after reset ----------------
    always_comb begin
        w_cfg_nxt = r_cfg_state;
        if (r_cfg_state == C_SEND && r_cfg_tvalid && bus.m_axis_cfg_tready) w_cfg_nxt = C_DONE;
    end

    // tvalid is registered so it stays low throughout reset.
    always_ff @(posedge iclk) begin
        if (!irst) begin
            r_cfg_state  <= C_SEND;
            r_cfg_tvalid <= 1'b0;
        end else begin
            r_cfg_state  <= w_cfg_nxt;
            r_cfg_tvalid <= (w_cfg_nxt == C_SEND);
        end
    end

    assign bus.m_axis_cfg_tvalid = r_cfg_tvalid;
    assign bus.m_axis_cfg_tdata  = r_cfg_tvalid ? pCFG_WORD : 16'h0000;

    // ---------------- write side ----------------
    // Enough space for a whole frame <=> used <= depth - frame length.
    assign w_used = r_wr_ptr - r_rd_ptr;

    always_comb begin
        w_wr_nxt     = r_wr_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_commit_nxt = r_commit_ptr;
        w_wcnt_nxt   = r_wcnt;
        w_we         = 1'b0;
        w_err        = 1'b0;
        w_ovf_set    = 1'b0;
        if (bus.fr_sync_ival) begin
            case (r_wr_state)
                W_IDLE: begin
                    if (bus.fr_sync_isop) begin
                        if (bus.fr_sync_ilast) begin
                            w_err = 1'b1;
                        end else if (w_used <= c_MAX_USED) begin
                            w_we         = 1'b1;
                            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                            w_wcnt_nxt   = c_CW'(1);
                            w_wr_nxt     = W_FRAME;
                        end else begin
                            w_ovf_set = 1'b1;
                            w_wr_nxt  = W_DROP;
                        end
                    end
                end
                W_FRAME: begin
                    if (bus.fr_sync_isop || (bus.fr_sync_ilast != (r_wcnt == c_LAST_CNT))) begin
                        w_wr_ptr_nxt = r_commit_ptr;
                        w_err        = 1'b1;
                        w_wr_nxt     = W_IDLE;
                    end else if (bus.fr_sync_ilast) begin
                        w_we         = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                        w_commit_nxt = r_wr_ptr + 1'b1;
                        w_wr_nxt     = W_IDLE;
                    end else begin
                        w_we         = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                        w_wcnt_nxt   = r_wcnt + 1'b1;
                    end
                end
                W_DROP: begin
                    if (bus.fr_sync_ilast) w_wr_nxt = W_IDLE;
                end
                default: w_wr_nxt = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge iclk) begin
        if (!irst) begin
            r_wr_state   <= W_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_wcnt       <= '0;
            r_ovf        <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_wr_state   <= w_wr_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_commit_ptr <= w_commit_nxt;
            r_wcnt       <= w_wcnt_nxt;
            r_ovf        <= r_ovf | w_ovf_set;
            r_frame_err  <= w_err;
        end
    end

    feeder_sdp_ram #(
        .pDW (c_SW),
        .pAW (c_AW)
    ) u_ram (
        .iclk    (iclk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[c_AW-1:0]),
        .i_wdata (bus.fr_sync_idata),
        .i_re    (w_re),
        .i_raddr (r_rd_ptr[c_AW-1:0]),
        .o_rdata (w_rdata)
    );

    // ---------------- read side: RAM register as skid, then output register ----------------
    assign w_avail = (r_commit_ptr != r_rd_ptr);
    assign w_load  = r_pend && (!r_tvalid || bus.m_axis_data_tready) && (r_cfg_state == C_DONE);
    assign w_re    = w_avail && (!r_pend || w_load);

    always_ff @(posedge iclk) begin
        if (!irst) begin
            r_rd_ptr <= '0;
            r_pend   <= 1'b0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_rcnt   <= '0;
        end else begin
            if (w_re) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_re) r_pend <= 1'b1;
            else if (w_load) r_pend <= 1'b0;
            if (w_load) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_rdata;
                r_tlast  <= (r_rcnt == c_LAST_CNT);
                r_rcnt   <= (r_rcnt == c_LAST_CNT) ? '0 : r_rcnt + 1'b1;
            end else if (bus.m_axis_data_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign bus.m_axis_data_tvalid = r_tvalid;
    assign bus.m_axis_data_tdata  = r_tdata;
    assign bus.m_axis_data_tlast  = r_tlast;
    assign bus.ostat_overflow     = r_ovf;
    assign bus.ostat_frame_err    = r_frame_err;

`ifdef FEEDER_STATS_EN
    logic [15:0] r_frames;
    always_ff @(posedge iclk) begin
        if (!irst) r_frames <= '0;
        else if (r_tvalid && bus.m_axis_data_tready && r_tlast) r_frames <= r_frames + 1'b1;
    end
    assign bus.ostat_frames = r_frames;
`else
    assign bus.ostat_frames = 16'h0000;
`endif
endmodule
`default_nettype wire
